clk_div_multi: RTL and testbench

- Multi-channel programmable clock divider / tick generator.
- Each of NUM_CH channels has its own runtime period, enable, restart and output mode.
- Period changes are shadowed: a new period takes effect only at the channel's next wrap, so output edges never glitch.
- Feeds game-timing logic (fall speed, input repeat, display scan) with square waves or single-cycle clock-enable ticks, all from the one system clock.

---
 rtl/clk_div_multi_if.sv | 16 +
 rtl/clk_div_multi.sv | 79 +++++++
 tb/tb_clk_div_multi.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: per-channel enables, modes, restarts,
// period bounds in, divided clocks and wrap ticks out.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH-1:0]       restart;
  logic [NUM_CH*CNT_W-1:0] upperbound;
  logic [NUM_CH-1:0]       clkdiv;
  logic [NUM_CH-1:0]       tick;

  modport master (output en, mode, restart, upperbound, input clkdiv, tick);
  modport slave  (input en, mode, restart, upperbound, output clkdiv, tick);
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: each channel counts 0..bound and wraps,
// producing a square wave (toggle) or one-cycle pulse plus a wrap tick.
module clk_div_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             restart,
  input  logic [CNT_W-1:0] ub,
  output logic             clkdiv,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] bound;
  logic             armed;

  // bound is a shadow of ub, only sampled at load or wrap so edges never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      bound  <= '0;
      armed  <= 1'b0;
      clkdiv <= 1'b0;
      tick   <= 1'b0;
    end else if (restart) begin
      cnt    <= '0;
      armed  <= 1'b0;
      clkdiv <= 1'b0;
      tick   <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
      if (mode) clkdiv <= 1'b0;
    end else if (!armed) begin
      bound <= ub;
      cnt   <= '0;
      armed <= 1'b1;
      tick  <= 1'b0;
    end else if (cnt >= bound) begin
      cnt    <= '0;
      bound  <= ub;
      tick   <= 1'b1;
      clkdiv <= mode ? 1'b1 : ~clkdiv;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
      if (mode) clkdiv <= 1'b0;
    end
  end
endmodule

module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input logic           clk,
  input logic           rst,
  clk_div_multi_if.slave bus
);
  logic [NUM_CH-1:0] clkdiv_v;
  logic [NUM_CH-1:0] tick_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en[i]),
      .mode    (bus.mode[i]),
      .restart (bus.restart[i]),
      .ub      (bus.upperbound[i*CNT_W +: CNT_W]),
      .clkdiv  (clkdiv_v[i]),
      .tick    (tick_v[i])
    );
  end

  assign bus.clkdiv = clkdiv_v;
  assign bus.tick   = tick_v;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (2 channels, 8-bit counters).
module tb_clk_div_multi;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, ".clkdiv0"}, bus.clkdiv[0], 1'b0);
    chk({tag, ".clkdiv1"}, bus.clkdiv[1], 1'b0);
    chk({tag, ".tick0"},   bus.tick[0],   1'b0);
    chk({tag, ".tick1"},   bus.tick[1],   1'b0);
  endtask

  initial begin
    bus.en = '0; bus.mode = '0; bus.restart = '0; bus.upperbound = '0;
    #23;
    chk_all0("reset");
    @(negedge clk);
    rst = 1'b0;

    // ch0 toggle, bound 3: load at e1, ticks at e5/e9/e13
    bus.en[0] = 1'b1;
    bus.upperbound[0 +: CNT_W] = 8'd3;
    for (int e = 1; e <= 13; e++) begin
      edge_step();
      chk($sformatf("t1.tick0.e%0d", e), bus.tick[0], (e == 5 || e == 9 || e == 13));
      chk($sformatf("t1.clk0.e%0d", e), bus.clkdiv[0], ((e >= 5 && e < 9) || e >= 13));
      chk($sformatf("t1.tick1.e%0d", e), bus.tick[1], 1'b0);
      chk($sformatf("t1.clk1.e%0d", e), bus.clkdiv[1], 1'b0);
    end

    // ch0 paused with clkdiv=1 (toggle holds); ch1 pulse mode, bound 0
    bus.en[0] = 1'b0;
    bus.en[1] = 1'b1; bus.mode[1] = 1'b1;
    bus.upperbound[CNT_W +: CNT_W] = 8'd0;
    for (int e = 1; e <= 5; e++) begin
      edge_step();
      chk($sformatf("t2.tick1.e%0d", e), bus.tick[1], (e >= 2));
      chk($sformatf("t2.clk1.e%0d", e), bus.clkdiv[1], (e >= 2));
      chk($sformatf("t2.clk0hold.e%0d", e), bus.clkdiv[0], 1'b1);
      chk($sformatf("t2.tick0.e%0d", e), bus.tick[0], 1'b0);
    end
    bus.en[1] = 1'b0;
    edge_step();
    chk("t2.off.tick1", bus.tick[1], 1'b0);
    chk("t2.off.clk1", bus.clkdiv[1], 1'b0);

    // ch0 bound 9, switch to 2 mid-period: old bound finishes (tick e11), then every 3
    bus.restart[0] = 1'b1;
    edge_step();
    chk("t3.rst.clk0", bus.clkdiv[0], 1'b0);
    bus.restart[0] = 1'b0;
    bus.en[0] = 1'b1;
    bus.upperbound[0 +: CNT_W] = 8'd9;
    for (int e = 1; e <= 17; e++) begin
      edge_step();
      if (e == 5) bus.upperbound[0 +: CNT_W] = 8'd2;
      chk($sformatf("t3.tick0.e%0d", e), bus.tick[0], (e == 11 || e == 14 || e == 17));
      chk($sformatf("t3.clk0.e%0d", e), bus.clkdiv[0], ((e >= 11 && e < 14) || e >= 17));
    end

    // ch0 bound 3, pause 5 edges at cnt=2: tick moves from e5 to e10
    bus.restart[0] = 1'b1;
    edge_step();
    bus.restart[0] = 1'b0;
    bus.upperbound[0 +: CNT_W] = 8'd3;
    for (int e = 1; e <= 13; e++) begin
      edge_step();
      bus.en[0] = !(e >= 3 && e <= 7);
      chk($sformatf("t4.tick0.e%0d", e), bus.tick[0], (e == 10));
      chk($sformatf("t4.clk0.e%0d", e), bus.clkdiv[0], (e >= 10));
    end

    // restart on the would-be wrap edge (cnt=bound=3) suppresses the tick
    bus.restart[0] = 1'b1;
    edge_step();
    chk("t5.rst.tick0", bus.tick[0], 1'b0);
    chk("t5.rst.clk0", bus.clkdiv[0], 1'b0);
    bus.restart[0] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      edge_step();
      chk($sformatf("t5.tick0.e%0d", e), bus.tick[0], (e == 5));
      chk($sformatf("t5.clk0.e%0d", e), bus.clkdiv[0], (e == 5));
    end

    // async reset between edges, then reload on release
    bus.en[1] = 1'b1;
    edge_step();
    edge_step();
    chk("t6.pre.tick1", bus.tick[1], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk_all0("t6.async");
    edge_step();
    chk_all0("t6.held");
    #1 rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      edge_step();
      chk($sformatf("t6.tick0.e%0d", e), bus.tick[0], (e == 5));
      chk($sformatf("t6.clk0.e%0d", e), bus.clkdiv[0], (e == 5));
      chk($sformatf("t6.tick1.e%0d", e), bus.tick[1], (e >= 2));
      chk($sformatf("t6.clk1.e%0d", e), bus.clkdiv[1], (e >= 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
